// File: rtl/ibex_rvfi_cosim_checker.sv
// In-order co-simulation checker: buffers RVFI retirements and compares them
// against a reference-model stream, flagging the first divergence, overflow and stalls.
module ibex_rvfi_cosim_checker #(
    parameter int unsigned Depth         = 8,
    parameter bit          CheckRdWdata  = 1'b1,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       enable_i,
    input  logic                       rvfi_valid_i,
    input  logic [63:0]                rvfi_order_i,
    input  logic [31:0]                rvfi_pc_rdata_i,
    input  logic [31:0]                rvfi_insn_i,
    input  logic                       rvfi_trap_i,
    input  logic [4:0]                 rvfi_rd_addr_i,
    input  logic [31:0]                rvfi_rd_wdata_i,
    input  logic                       ref_valid_i,
    output logic                       ref_ready_o,
    input  logic [31:0]                ref_pc_i,
    input  logic [31:0]                ref_insn_i,
    input  logic                       ref_trap_i,
    input  logic [4:0]                 ref_rd_addr_i,
    input  logic [31:0]                ref_rd_wdata_i,
    output logic [31:0]                match_count_o,
    output logic                       mismatch_o,
    output logic [3:0]                 mismatch_field_o,
    output logic [63:0]                mismatch_order_o,
    output logic                       overflow_o,
    output logic                       timeout_o,
    output logic [$clog2(Depth+1)-1:0] fifo_level_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned LvlW = $clog2(Depth + 1);
    localparam int unsigned CntW = $clog2(TimeoutCycles + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FAIL = 2'd2
    } state_e;

    typedef struct packed {
        logic [63:0] order;
        logic [31:0] pc;
        logic [31:0] insn;
        logic        trap;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
    } entry_t;

    state_e          state;
    entry_t          mem [Depth];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic [CntW-1:0] stall_cnt;

    entry_t     head;
    entry_t     wr_entry;
    logic       run;
    logic       empty;
    logic       full;
    logic       fire;
    logic       push_req;
    logic       push;
    logic       drop;
    logic       stall_hit;
    logic [3:0] field;

    // Handshake, push/drop decision and field comparison against the FIFO head
    always_comb begin
        head      = mem[rd_ptr];
        wr_entry  = '{order: rvfi_order_i, pc: rvfi_pc_rdata_i, insn: rvfi_insn_i,
                      trap: rvfi_trap_i, rd_addr: rvfi_rd_addr_i, rd_wdata: rvfi_rd_wdata_i};
        run       = (state == RUN);
        empty     = (fifo_level_o == '0);
        full      = (fifo_level_o == LvlW'(Depth));
        ref_ready_o = run && !empty;
        fire      = ref_valid_i && ref_ready_o;
        push_req  = run && enable_i && rvfi_valid_i;
        push      = push_req && (!full || fire);
        drop      = push_req && full && !fire;
        stall_hit = run && enable_i && !empty && !ref_valid_i
                    && (stall_cnt == CntW'(TimeoutCycles - 1));
        field     = '0;
        field[3]  = head.trap != ref_trap_i;
        field[2]  = head.pc != ref_pc_i;
        field[1]  = head.insn != ref_insn_i;
        field[0]  = (head.rd_addr != ref_rd_addr_i)
                    || (CheckRdWdata && (head.rd_addr != 5'd0) && !head.trap
                        && (head.rd_wdata != ref_rd_wdata_i));
    end

    // FIFO storage carries no reset; validity is tracked by the pointers
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state            <= IDLE;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            fifo_level_o     <= '0;
            stall_cnt        <= '0;
            match_count_o    <= '0;
            mismatch_o       <= 1'b0;
            mismatch_field_o <= '0;
            mismatch_order_o <= '0;
            overflow_o       <= 1'b0;
            timeout_o        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable_i) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (fire) begin
                        if (field != 4'd0) begin
                            mismatch_o       <= 1'b1;
                            mismatch_field_o <= field;
                            mismatch_order_o <= head.order;
                        end else if (match_count_o != 32'hFFFF_FFFF) begin
                            match_count_o <= match_count_o + 32'd1;
                        end
                    end
                    if (!enable_i) begin
                        // Disable discards buffered retirements but keeps the sticky results
                        state        <= IDLE;
                        wr_ptr       <= '0;
                        rd_ptr       <= '0;
                        fifo_level_o <= '0;
                        stall_cnt    <= '0;
                    end else begin
                        if (push) begin
                            wr_ptr <= wr_ptr + PtrW'(1);
                        end
                        if (fire) begin
                            rd_ptr <= rd_ptr + PtrW'(1);
                        end
                        fifo_level_o <= fifo_level_o + LvlW'(push) - LvlW'(fire);
                        if (empty || fire) begin
                            stall_cnt <= '0;
                        end else begin
                            stall_cnt <= stall_cnt + CntW'(1);
                        end
                        if (drop) begin
                            overflow_o <= 1'b1;
                        end
                        if (stall_hit) begin
                            timeout_o <= 1'b1;
                        end
                    end
                    if ((fire && (field != 4'd0)) || drop || stall_hit) begin
                        state <= FAIL;
                    end
                end
                FAIL: begin
                    state <= FAIL;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ibex_rvfi_cosim_checker.sv
// Randomised bench for ibex_rvfi_cosim_checker against a queue-based reference model.
module tb_ibex_rvfi_cosim_checker;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 1024;

    typedef struct packed {
        logic [63:0] order;
        logic [31:0] pc;
        logic [31:0] insn;
        logic        trap;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        rvfi_valid = 1'b0;
    ent_t        rv = '0;
    logic        ref_valid = 1'b0;
    ent_t        rf = '0;
    logic        ref_ready;
    logic [31:0] match_count;
    logic        mismatch;
    logic [3:0]  mismatch_field;
    logic [63:0] mismatch_order;
    logic        overflow;
    logic        timeout;
    logic [3:0]  fifo_level;

    ibex_rvfi_cosim_checker #(
        .Depth(DEPTH), .CheckRdWdata(1'b1), .TimeoutCycles(TIMEOUT)
    ) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable),
        .rvfi_valid_i(rvfi_valid), .rvfi_order_i(rv.order), .rvfi_pc_rdata_i(rv.pc),
        .rvfi_insn_i(rv.insn), .rvfi_trap_i(rv.trap), .rvfi_rd_addr_i(rv.rd_addr),
        .rvfi_rd_wdata_i(rv.rd_wdata),
        .ref_valid_i(ref_valid), .ref_ready_o(ref_ready), .ref_pc_i(rf.pc),
        .ref_insn_i(rf.insn), .ref_trap_i(rf.trap), .ref_rd_addr_i(rf.rd_addr),
        .ref_rd_wdata_i(rf.rd_wdata),
        .match_count_o(match_count), .mismatch_o(mismatch), .mismatch_field_o(mismatch_field),
        .mismatch_order_o(mismatch_order), .overflow_o(overflow), .timeout_o(timeout),
        .fifo_level_o(fifo_level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: retirement queue plus sticky results
    ent_t        mq[$];
    bit          m_run, m_fail, m_mis, m_ovf, m_to;
    int          m_stall;
    logic [31:0] m_count;
    logic [3:0]  m_field;
    logic [63:0] m_order;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic ent_t rand_ent(input int order);
        ent_t e;
        e.order    = 64'(order);
        e.pc       = $urandom;
        e.insn     = $urandom;
        e.trap     = ($urandom_range(0, 7) == 0);
        e.rd_addr  = 5'($urandom);
        e.rd_wdata = $urandom;
        return e;
    endfunction

    function automatic logic [3:0] diff(input ent_t d, input ent_t r);
        logic [3:0] f;
        f[3] = d.trap != r.trap;
        f[2] = d.pc != r.pc;
        f[1] = d.insn != r.insn;
        f[0] = (d.rd_addr != r.rd_addr) ||
               ((d.rd_addr != 0) && !d.trap && (d.rd_wdata != r.rd_wdata));
        return f;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_run = 0; m_fail = 0; m_mis = 0; m_ovf = 0; m_to = 0;
        m_stall = 0; m_count = '0; m_field = '0; m_order = '0;
    endtask

    // One clock: check the handshake, advance the model, then check all registered outputs
    task automatic cycle(output bit fired);
        bit   nf;
        int   pre;
        ent_t h;
        logic [3:0] f;
        @(negedge clk);
        check("ref_ready", 64'(ref_ready), 64'(m_run && mq.size() > 0));
        fired = m_run && mq.size() > 0 && ref_valid;
        if (rst) begin
            model_reset();
        end else if (m_fail) begin
        end else if (!m_run) begin
            if (enable) m_run = 1;
        end else begin
            nf  = 0;
            pre = mq.size();
            if (fired) begin
                h = mq.pop_front();
                f = diff(h, rf);
                if (f != 0) begin
                    m_mis = 1; m_field = f; m_order = h.order; nf = 1;
                end else if (m_count != 32'hFFFF_FFFF) begin
                    m_count++;
                end
            end
            if (!enable) begin
                mq.delete(); m_stall = 0; m_run = 0;
            end else begin
                if (rvfi_valid) begin
                    if (mq.size() < DEPTH) mq.push_back(rv);
                    else begin m_ovf = 1; nf = 1; end
                end
                if (pre == 0 || fired) m_stall = 0;
                else begin
                    m_stall++;
                    if (m_stall == TIMEOUT) begin m_to = 1; nf = 1; end
                end
            end
            if (nf) begin m_run = 0; m_fail = 1; end
        end
        @(posedge clk);
        #1;
        check("fifo_level", 64'(fifo_level), 64'(mq.size()));
        check("match_count", 64'(match_count), 64'(m_count));
        check("mismatch", 64'(mismatch), 64'(m_mis));
        check("mismatch_field", 64'(mismatch_field), 64'(m_field));
        check("mismatch_order", mismatch_order, m_order);
        check("overflow", 64'(overflow), 64'(m_ovf));
        check("timeout", 64'(timeout), 64'(m_to));
    endtask

    task automatic idle_inputs();
        rvfi_valid = 0;
        rv         = rand_ent(0);
        ref_valid  = 0;
        rf         = rand_ent(0);
    endtask

    task automatic start();
        bit f;
        idle_inputs();
        enable = 0;
        rst = 1; cycle(f); cycle(f);
        rst = 0; enable = 1; cycle(f);
    endtask

    // Retire n entries with ref copies offered one cycle later; entry bad_idx gets fault `kind`
    // kind 0: rd_wdata 2 vs 1 at rd_addr=rd, 1: trap, 2: pc, 3: insn, 4: rd_addr
    task automatic stream(input int n, input int bad_idx, input int kind, input logic [4:0] rd,
                          input bit dense, input int max_cyc);
        ent_t src[$];
        int   avail[$];
        int   r = 0;
        bit   f;
        ent_t e, x;
        for (int c = 0; c < max_cyc; c++) begin
            if (src.size() > 0 && avail[0] <= c) begin
                ref_valid = 1; rf = src[0];
            end else begin
                ref_valid = 0; rf = rand_ent(0);
            end
            if (r < n && (dense || $urandom_range(0, 3) != 0)) begin
                e = rand_ent(r + 1);
                x = e;
                if (r + 1 == bad_idx) begin
                    case (kind)
                        0: begin
                            e.trap = 0; x.trap = 0; e.rd_addr = rd; x.rd_addr = rd;
                            e.rd_wdata = 32'h2; x.rd_wdata = 32'h1;
                        end
                        1: x.trap = ~e.trap;
                        2: x.pc = e.pc ^ 32'h4;
                        3: x.insn = e.insn ^ 32'h8000_0000;
                        default: x.rd_addr = e.rd_addr + 5'd1;
                    endcase
                end
                rvfi_valid = 1; rv = e;
                src.push_back(x); avail.push_back(c + 1);
                r++;
            end else begin
                rvfi_valid = 0; rv = rand_ent(0);
            end
            cycle(f);
            if (f) begin
                void'(src.pop_front());
                void'(avail.pop_front());
            end
            if (m_fail || (r == n && src.size() == 0)) break;
        end
        idle_inputs();
    endtask

    task automatic push_n(input int n, input int base);
        bit f;
        for (int i = 0; i < n; i++) begin
            ref_valid = 0;
            rvfi_valid = 1; rv = rand_ent(base + i);
            cycle(f);
        end
        idle_inputs();
    endtask

    initial begin
        bit f;
        int k;
        int idx;
        logic [3:0] kf;
        model_reset();
        idle_inputs();

        // Reset state
        rst = 1; cycle(f); cycle(f);
        check("rst_level", 64'(fifo_level), 64'd0);
        check("rst_count", 64'(match_count), 64'd0);
        check("rst_flags", 64'({mismatch, overflow, timeout, ref_ready}), 64'd0);

        // 20 matching retirements
        start();
        stream(20, 0, 0, 5'd0, 1'b1, 300);
        check("m20_count", 64'(match_count), 64'd20);
        check("m20_mismatch", 64'(mismatch), 64'd0);
        check("m20_level", 64'(fifo_level), 64'd0);

        // rd_wdata mismatch on third entry
        start();
        stream(6, 3, 0, 5'd5, 1'b1, 200);
        cycle(f);
        check("wd_mismatch", 64'(mismatch), 64'd1);
        check("wd_field", 64'(mismatch_field), 64'b0001);
        check("wd_order", mismatch_order, 64'd3);
        check("wd_count", 64'(match_count), 64'd2);
        check("wd_ready", 64'(ref_ready), 64'd0);

        // Same data difference on x0 is ignored
        start();
        stream(6, 3, 0, 5'd0, 1'b1, 200);
        check("x0_count", 64'(match_count), 64'd6);
        check("x0_mismatch", 64'(mismatch), 64'd0);

        // Random field faults at random positions with random retirement gaps
        for (int kind = 1; kind <= 4; kind++) begin
            idx = $urandom_range(1, 6);
            kf  = 4'b1 << (4 - kind);
            start();
            stream(8, idx, kind, 5'd0, 1'b0, 400);
            check("rf_field", 64'(mismatch_field), 64'(kf));
            check("rf_order", mismatch_order, 64'(idx));
            check("rf_count", 64'(match_count), 64'(idx - 1));
        end

        // Overflow: 9 back-to-back retirements, reference silent
        start();
        push_n(9, 1);
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_level", 64'(fifo_level), 64'd8);
        check("ovf_ready", 64'(ref_ready), 64'd0);

        // Full FIFO with push and compare in the same cycle
        start();
        push_n(8, 1);
        rvfi_valid = 1; rv = rand_ent(9);
        ref_valid = 1; rf = mq[0];
        cycle(f);
        idle_inputs();
        check("fullpp_ovf", 64'(overflow), 64'd0);
        check("fullpp_level", 64'(fifo_level), 64'd8);
        check("fullpp_count", 64'(match_count), 64'd1);

        // Timeout after a single retirement
        start();
        push_n(1, 1);
        k = 0;
        for (int i = 1; i <= TIMEOUT + 50; i++) begin
            cycle(f);
            k = i;
            if (timeout) break;
        end
        check("to_cycle", 64'(k), 64'(TIMEOUT));
        check("to_flag", 64'(timeout), 64'd1);

        // Disable with 3 buffered entries, then resume
        start();
        stream(2, 0, 0, 5'd0, 1'b1, 100);
        push_n(3, 10);
        check("dis_pre_level", 64'(fifo_level), 64'd3);
        enable = 0; cycle(f);
        check("dis_level", 64'(fifo_level), 64'd0);
        check("dis_count", 64'(match_count), 64'd2);
        check("dis_flags", 64'({mismatch, overflow, timeout}), 64'd0);
        enable = 1; cycle(f);
        stream(5, 0, 0, 5'd0, 1'b0, 200);
        check("resume_count", 64'(match_count), 64'd7);

        // Reset mid-operation
        push_n(4, 20);
        rst = 1; cycle(f);
        rst = 0;
        check("mid_rst_level", 64'(fifo_level), 64'd0);
        check("mid_rst_count", 64'(match_count), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
